// File: rtl/washer_program_ctrl.sv
// -----------------------------------------------------------------------------
// washer_program_ctrl
//
// Program sequencer for a front-loading washer. A Moore FSM walks the tub
// through soap fill, wash, drain, a configurable number of rinse passes and a
// final spin. Fill and drain phases are guarded by a timeout, the door and an
// abort request are monitored throughout the program, and a pause input holds
// the program timer and parks the valves and motor without unlocking the door.
//
// Parameters
//   TW            width of the in-state cycle timer; must hold
//                 max(WASH_CYC, RINSE_CYC, SPIN_CYC, FILL_TIMEOUT)
//   WASH_CYC      WASH length in unpaused cycles (>= 1)
//   RINSE_CYC     length of each RINSE pass in unpaused cycles (>= 1)
//   SPIN_CYC      SPIN length in unpaused cycles (>= 1)
//   N_RINSE       number of rinse passes, 0..7 (0 goes from wash drain to spin)
//   FILL_TIMEOUT  cycles allowed in a fill or drain state before FAULT (>= 1)
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   start         run request (also released to leave DONE)
//   door_closed   door switch, 1 = closed
//   filled        water level reached
//   drained       tub empty
//   detergent     soap present
//   pause         hold program
//   abort         cancel program, drain and return to IDLE
//   door_lock     door latch solenoid
//   fill_valve_on inlet valve
//   drain_valve_on drain pump / valve
//   motor_on      drum motor
//   soap_wash     wash phase indicator
//   water_wash    rinse phase indicator
//   spin          spin phase indicator
//   done          program finished
//   fault         fault latched (cleared only by rst)
//   state_o       current state code
//   rinse_cnt_o   completed rinse passes
// -----------------------------------------------------------------------------
module washer_program_ctrl #(
    parameter int TW           = 8,
    parameter int WASH_CYC     = 20,
    parameter int RINSE_CYC    = 10,
    parameter int SPIN_CYC     = 15,
    parameter int N_RINSE      = 2,
    parameter int FILL_TIMEOUT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       door_closed,
    input  logic       filled,
    input  logic       drained,
    input  logic       detergent,
    input  logic       pause,
    input  logic       abort,
    output logic       door_lock,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       motor_on,
    output logic       soap_wash,
    output logic       water_wash,
    output logic       spin,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_o,
    output logic [2:0] rinse_cnt_o
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL_SOAP   = 4'd1,
        WASH        = 4'd2,
        DRAIN_W     = 4'd3,
        FILL_RINSE  = 4'd4,
        RINSE       = 4'd5,
        DRAIN_R     = 4'd6,
        SPIN        = 4'd7,
        DONE        = 4'd8,
        ABORT_DRAIN = 4'd9,
        FAULT       = 4'd10
    } state_t;

    // Terminal timer values: a timed state of N cycles leaves when the timer
    // reads N-1 on an unpaused cycle.
    localparam logic [TW-1:0] WASH_LAST  = TW'(WASH_CYC - 1);
    localparam logic [TW-1:0] RINSE_LAST = TW'(RINSE_CYC - 1);
    localparam logic [TW-1:0] SPIN_LAST  = TW'(SPIN_CYC - 1);
    localparam logic [TW-1:0] FILL_LAST  = TW'(FILL_TIMEOUT - 1);
    localparam logic [2:0]    RINSE_PASSES = 3'(N_RINSE);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    rinse_cnt;
    logic          rinse_inc;
    logic          in_prog;
    logic          fill_to;
    logic          wash_end;
    logic          rinse_end;
    logic          spin_end;

    // Pause freezes both the timed-state countdown and the fill/drain watchdog.
    assign fill_to   = (timer == FILL_LAST)  && !pause;
    assign wash_end  = (timer == WASH_LAST)  && !pause;
    assign rinse_end = (timer == RINSE_LAST) && !pause;
    assign spin_end  = (timer == SPIN_LAST)  && !pause;

    // States in which abort and the door switch are honoured.
    assign in_prog = (state >= FILL_SOAP) && (state <= SPIN);

    // ---- state, timer and rinse counter registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            rinse_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Timer restarts on every state change; in untimed states it is
            // free-running and its value is ignored, so wrap-around is harmless.
            if (state_nxt != state) begin
                timer <= '0;
            end else if (!pause) begin
                timer <= timer + TW'(1);
            end

            if ((state_nxt == IDLE) && (state != IDLE)) begin
                rinse_cnt <= '0;
            end else if (rinse_inc) begin
                rinse_cnt <= rinse_cnt + 3'd1;
            end
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        rinse_inc = 1'b0;

        if (in_prog && abort) begin
            state_nxt = ABORT_DRAIN;
        end else if (in_prog && !door_closed) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (start && door_closed) begin
                        state_nxt = FILL_SOAP;
                    end
                end
                FILL_SOAP: begin
                    if (filled && detergent) begin
                        state_nxt = WASH;
                    end else if (fill_to) begin
                        state_nxt = FAULT;
                    end
                end
                WASH: begin
                    if (wash_end) begin
                        state_nxt = DRAIN_W;
                    end
                end
                DRAIN_W: begin
                    if (drained) begin
                        state_nxt = (RINSE_PASSES == 3'd0) ? SPIN : FILL_RINSE;
                    end else if (fill_to) begin
                        state_nxt = FAULT;
                    end
                end
                FILL_RINSE: begin
                    if (filled) begin
                        state_nxt = RINSE;
                    end else if (fill_to) begin
                        state_nxt = FAULT;
                    end
                end
                RINSE: begin
                    if (rinse_end) begin
                        state_nxt = DRAIN_R;
                    end
                end
                DRAIN_R: begin
                    if (drained) begin
                        // Decide on the count this pass will leave behind.
                        rinse_inc = 1'b1;
                        state_nxt = ((rinse_cnt + 3'd1) == RINSE_PASSES) ? SPIN : FILL_RINSE;
                    end else if (fill_to) begin
                        state_nxt = FAULT;
                    end
                end
                SPIN: begin
                    if (spin_end) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_nxt = IDLE;
                    end
                end
                ABORT_DRAIN: begin
                    if (drained) begin
                        state_nxt = IDLE;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ---- Moore outputs (pause gates actuators, never the door lock) ----
    always_comb begin
        door_lock      = 1'b0;
        fill_valve_on  = 1'b0;
        drain_valve_on = 1'b0;
        motor_on       = 1'b0;
        soap_wash      = 1'b0;
        water_wash     = 1'b0;
        spin           = 1'b0;
        done           = 1'b0;
        fault          = 1'b0;

        case (state)
            FILL_SOAP, FILL_RINSE: begin
                door_lock     = 1'b1;
                fill_valve_on = !pause;
            end
            WASH: begin
                door_lock = 1'b1;
                soap_wash = 1'b1;
                motor_on  = !pause;
            end
            DRAIN_W, DRAIN_R: begin
                door_lock      = 1'b1;
                drain_valve_on = !pause;
            end
            RINSE: begin
                door_lock  = 1'b1;
                water_wash = 1'b1;
                motor_on   = !pause;
            end
            SPIN: begin
                door_lock      = 1'b1;
                drain_valve_on = !pause;
                motor_on       = !pause;
                spin           = !pause;
            end
            DONE: begin
                done = 1'b1;
            end
            ABORT_DRAIN: begin
                // Water must leave the tub regardless of pause.
                door_lock      = 1'b1;
                drain_valve_on = 1'b1;
            end
            FAULT: begin
                // Keep the door shut until the tub is confirmed empty.
                door_lock      = !drained;
                drain_valve_on = 1'b1;
                fault          = 1'b1;
            end
            default: begin
                door_lock = 1'b0;
            end
        endcase
    end

    assign state_o     = state;
    assign rinse_cnt_o = rinse_cnt;

endmodule

// File: tb/tb_washer_program_ctrl.sv
// -----------------------------------------------------------------------------
// tb_washer_program_ctrl
//
// Directed bench for washer_program_ctrl. A negedge monitor records each state
// visit (code, length, motor cycles, wash/rinse/spin indicator cycles) and
// compares it against expectations queued by the stimulus. A second instance
// with N_RINSE=0 and short durations covers the no-rinse path.
// -----------------------------------------------------------------------------
module tb_washer_program_ctrl;

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_FILL_SOAP   = 4'd1;
    localparam logic [3:0] S_WASH        = 4'd2;
    localparam logic [3:0] S_DRAIN_W     = 4'd3;
    localparam logic [3:0] S_FILL_RINSE  = 4'd4;
    localparam logic [3:0] S_RINSE       = 4'd5;
    localparam logic [3:0] S_DRAIN_R     = 4'd6;
    localparam logic [3:0] S_SPIN        = 4'd7;
    localparam logic [3:0] S_DONE        = 4'd8;
    localparam logic [3:0] S_ABORT_DRAIN = 4'd9;
    localparam logic [3:0] S_FAULT       = 4'd10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic start = 1'b0, door_closed = 1'b0, filled = 1'b0, drained = 1'b0;
    logic detergent = 1'b0, pause = 1'b0, abort = 1'b0;
    logic door_lock, fill_valve_on, drain_valve_on, motor_on;
    logic soap_wash, water_wash, spin, done, fault;
    logic [3:0] state_o;
    logic [2:0] rinse_cnt_o;
    logic [8:0] outs;
    assign outs = {door_lock, fill_valve_on, drain_valve_on, motor_on,
                   soap_wash, water_wash, spin, done, fault};

    washer_program_ctrl u_dut (
        .clk(clk), .rst(rst),
        .start(start), .door_closed(door_closed), .filled(filled),
        .drained(drained), .detergent(detergent), .pause(pause), .abort(abort),
        .door_lock(door_lock), .fill_valve_on(fill_valve_on),
        .drain_valve_on(drain_valve_on), .motor_on(motor_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .spin(spin),
        .done(done), .fault(fault), .state_o(state_o), .rinse_cnt_o(rinse_cnt_o)
    );

    // Second instance: no rinse passes, short timings
    logic b_start = 1'b0, b_door = 1'b0, b_filled = 1'b0, b_drained = 1'b0, b_det = 1'b0;
    logic b_door_lock, b_fill, b_drain, b_motor, b_soap, b_water, b_spin, b_done, b_fault;
    logic [3:0] b_state;
    logic [2:0] b_rinse;

    washer_program_ctrl #(
        .TW(4), .WASH_CYC(3), .RINSE_CYC(2), .SPIN_CYC(4), .N_RINSE(0), .FILL_TIMEOUT(6)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .start(b_start), .door_closed(b_door), .filled(b_filled),
        .drained(b_drained), .detergent(b_det), .pause(1'b0), .abort(1'b0),
        .door_lock(b_door_lock), .fill_valve_on(b_fill),
        .drain_valve_on(b_drain), .motor_on(b_motor),
        .soap_wash(b_soap), .water_wash(b_water), .spin(b_spin),
        .done(b_done), .fault(b_fault), .state_o(b_state), .rinse_cnt_o(b_rinse)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected state visits; -1 means "don't care".
    typedef struct {
        string      tag;
        logic [3:0] st;
        int         len;
        int         mot;
        int         act;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input string tag, input logic [3:0] st,
                        input int len, input int mot, input int act);
        exp_t e;
        e.tag = tag; e.st = st; e.len = len; e.mot = mot; e.act = act;
        exp_q.push_back(e);
    endtask

    logic [3:0] cur_st  = 4'd0;
    int         cur_len = 0;
    int         cur_mot = 0;
    int         cur_act = 0;
    int         done_cycles = 0;

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) done_cycles++;
        if (state_o !== cur_st) begin
            chk("sb_has_expectation", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.tag, "_state"}, cur_st, e.st);
                if (e.len >= 0) chk({e.tag, "_len"}, cur_len, e.len);
                if (e.mot >= 0) chk({e.tag, "_motor_cycles"}, cur_mot, e.mot);
                if (e.act >= 0) chk({e.tag, "_phase_cycles"}, cur_act, e.act);
            end
            cur_st  = state_o;
            cur_len = 1;
            cur_mot = (motor_on === 1'b1) ? 1 : 0;
            cur_act = ((soap_wash | water_wash | spin) === 1'b1) ? 1 : 0;
        end else begin
            cur_len++;
            if (motor_on === 1'b1) cur_mot++;
            if ((soap_wash | water_wash | spin) === 1'b1) cur_act++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Poll (bounded) until the selected instance reports the given state.
    task automatic wait_st(input bit b, input logic [3:0] code, input int budget, input string tag);
        int n = 0;
        while (((b ? b_state : state_o) !== code) && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, b ? b_state : state_o, code);
    endtask

    // Drive the plant for a default program until RINSE (first pass) or SPIN.
    task automatic drive_prog(input logic [3:0] stop_at);
        bit stop = 1'b0;
        door_closed = 1'b1;
        start = 1'b1;
        wait_st(0, S_FILL_SOAP, 4, "to_fill_soap");
        chk("fill_valve_in_fill", fill_valve_on, 1);
        start = 1'b0; filled = 1'b1; detergent = 1'b1;
        wait_st(0, S_WASH, 4, "to_wash");
        chk("soap_wash_in_wash", soap_wash, 1);
        filled = 1'b0; detergent = 1'b0;
        wait_st(0, S_DRAIN_W, 25, "to_drain_w");
        drained = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (!stop) begin
                wait_st(0, S_FILL_RINSE, 4, "to_fill_rinse");
                chk("rinse_cnt_at_fill_rinse", rinse_cnt_o, p);
                drained = 1'b0; filled = 1'b1;
                wait_st(0, S_RINSE, 4, "to_rinse");
                chk("water_wash_in_rinse", water_wash, 1);
                filled = 1'b0;
                if (stop_at == S_RINSE) begin
                    stop = 1'b1;
                end else begin
                    wait_st(0, S_DRAIN_R, 15, "to_drain_r");
                    drained = 1'b1;
                end
            end
        end
        if (!stop) begin
            wait_st(0, S_SPIN, 4, "to_spin");
            drained = 1'b0;
        end
    endtask

    int done_before;

    initial begin
        // Reset state
        step(2);
        chk("rst_state", state_o, S_IDLE);
        chk("rst_outputs", outs, 0);
        chk("rst_rinse_cnt", rinse_cnt_o, 0);
        rst = 1'b0;

        // Start ignored with the door open
        start = 1'b1; door_closed = 1'b0;
        step(3);
        chk("idle_door_open", state_o, S_IDLE);
        start = 1'b0;

        // Full default program
        push("s1_idle", S_IDLE, -1, -1, -1);
        push("s1_fill_soap", S_FILL_SOAP, 1, 0, 0);
        push("s1_wash", S_WASH, 20, 20, 20);
        push("s1_drain_w", S_DRAIN_W, 1, 0, 0);
        push("s1_fill_rinse1", S_FILL_RINSE, 1, 0, 0);
        push("s1_rinse1", S_RINSE, 10, 10, 10);
        push("s1_drain_r1", S_DRAIN_R, 1, 0, 0);
        push("s1_fill_rinse2", S_FILL_RINSE, 1, 0, 0);
        push("s1_rinse2", S_RINSE, 10, 10, 10);
        push("s1_drain_r2", S_DRAIN_R, 1, 0, 0);
        push("s1_spin", S_SPIN, 15, 15, 15);
        push("s1_done", S_DONE, 1, 0, 0);
        drive_prog(S_SPIN);
        chk("s1_spin_out", spin, 1);
        chk("s1_spin_drain", drain_valve_on, 1);
        chk("s1_spin_lock", door_lock, 1);
        chk("s1_rinse_cnt_spin", rinse_cnt_o, 2);
        wait_st(0, S_DONE, 20, "s1_to_done");
        chk("s1_done_out", done, 1);
        chk("s1_done_rinse_cnt", rinse_cnt_o, 2);
        chk("s1_done_unlock", door_lock, 0);
        wait_st(0, S_IDLE, 4, "s1_to_idle");
        chk("s1_idle_rinse_clr", rinse_cnt_o, 0);

        // Pause for 5 cycles during WASH, then abort from DRAIN_W
        push("s2_idle", S_IDLE, -1, -1, -1);
        push("s2_fill_soap", S_FILL_SOAP, 1, 0, 0);
        push("s2_wash", S_WASH, 25, 20, 25);
        push("s2_drain_w", S_DRAIN_W, 1, 0, 0);
        push("s2_abort_drain", S_ABORT_DRAIN, 1, 0, 0);
        start = 1'b1;
        wait_st(0, S_FILL_SOAP, 4, "s2_to_fill");
        start = 1'b0; filled = 1'b1; detergent = 1'b1;
        wait_st(0, S_WASH, 4, "s2_to_wash");
        filled = 1'b0; detergent = 1'b0;
        step(5);
        pause = 1'b1;
        repeat (5) begin
            #1;
            chk("s2_pause_motor", motor_on, 0);
            chk("s2_pause_lock", door_lock, 1);
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        wait_st(0, S_DRAIN_W, 30, "s2_to_drain_w");
        abort = 1'b1;
        wait_st(0, S_ABORT_DRAIN, 2, "s2_to_abort_drain");
        chk("s2_abort_drain_valve", drain_valve_on, 1);
        abort = 1'b0; drained = 1'b1;
        wait_st(0, S_IDLE, 2, "s2_to_idle");
        drained = 1'b0;

        // Door opened during RINSE
        push("s3_idle", S_IDLE, -1, -1, -1);
        push("s3_fill_soap", S_FILL_SOAP, 1, 0, 0);
        push("s3_wash", S_WASH, 20, 20, 20);
        push("s3_drain_w", S_DRAIN_W, 1, 0, 0);
        push("s3_fill_rinse", S_FILL_RINSE, 1, 0, 0);
        push("s3_rinse", S_RINSE, 4, 4, 4);
        push("s3_fault", S_FAULT, -1, -1, -1);
        drive_prog(S_RINSE);
        step(3);
        door_closed = 1'b0;
        step(1);
        chk("s3_door_fault_state", state_o, S_FAULT);
        chk("s3_door_motor_off", motor_on, 0);
        chk("s3_fault_out", fault, 1);
        chk("s3_fault_lock", door_lock, 1);
        door_closed = 1'b1; start = 1'b1;
        step(3);
        chk("s3_fault_sticky", state_o, S_FAULT);
        start = 1'b0; drained = 1'b1;
        #1;
        chk("s3_fault_unlock_drained", door_lock, 0);
        chk("s3_fault_drain_valve", drain_valve_on, 1);
        #1; rst = 1'b1;
        #1;
        chk("s3_rst_state", state_o, S_IDLE);
        step(1);
        rst = 1'b0; drained = 1'b0;

        // Fill timeout
        push("s4_idle", S_IDLE, -1, -1, -1);
        push("s4_fill_soap", S_FILL_SOAP, 50, 0, 0);
        push("s4_fault", S_FAULT, -1, -1, -1);
        start = 1'b1;
        wait_st(0, S_FILL_SOAP, 4, "s4_to_fill");
        start = 1'b0;
        step(49);
        chk("s4_still_filling", state_o, S_FILL_SOAP);
        step(1);
        chk("s4_timeout_state", state_o, S_FAULT);
        chk("s4_fault_out", fault, 1);
        chk("s4_drain_valve", drain_valve_on, 1);
        chk("s4_lock", door_lock, 1);
        step(2);
        chk("s4_lock_held", door_lock, 1);
        drained = 1'b1;
        #1;
        chk("s4_unlock_drained", door_lock, 0);
        #1; rst = 1'b1;
        #1;
        chk("s4_rst_state", state_o, S_IDLE);
        step(1);
        rst = 1'b0; drained = 1'b0;

        // Abort during SPIN
        done_before = done_cycles;
        push("s5_idle", S_IDLE, -1, -1, -1);
        push("s5_fill_soap", S_FILL_SOAP, 1, 0, 0);
        push("s5_wash", S_WASH, 20, 20, 20);
        push("s5_drain_w", S_DRAIN_W, 1, 0, 0);
        push("s5_fill_rinse1", S_FILL_RINSE, 1, 0, 0);
        push("s5_rinse1", S_RINSE, 10, 10, 10);
        push("s5_drain_r1", S_DRAIN_R, 1, 0, 0);
        push("s5_fill_rinse2", S_FILL_RINSE, 1, 0, 0);
        push("s5_rinse2", S_RINSE, 10, 10, 10);
        push("s5_drain_r2", S_DRAIN_R, 1, 0, 0);
        push("s5_spin", S_SPIN, 4, 4, 4);
        push("s5_abort_drain", S_ABORT_DRAIN, 1, 0, 0);
        drive_prog(S_SPIN);
        step(3);
        abort = 1'b1;
        step(1);
        chk("s5_abort_state", state_o, S_ABORT_DRAIN);
        chk("s5_abort_drain_valve", drain_valve_on, 1);
        chk("s5_abort_lock", door_lock, 1);
        chk("s5_abort_motor_off", motor_on, 0);
        abort = 1'b0; drained = 1'b1;
        step(1);
        chk("s5_abort_to_idle", state_o, S_IDLE);
        drained = 1'b0;
        step(2);
        chk("s5_done_never", done_cycles - done_before, 0);

        // Asynchronous reset mid-WASH
        push("s6_idle", S_IDLE, -1, -1, -1);
        push("s6_fill_soap", S_FILL_SOAP, 1, 0, 0);
        push("s6_wash", S_WASH, -1, -1, -1);
        start = 1'b1;
        wait_st(0, S_FILL_SOAP, 4, "s6_to_fill");
        start = 1'b0; filled = 1'b1; detergent = 1'b1;
        wait_st(0, S_WASH, 4, "s6_to_wash");
        filled = 1'b0; detergent = 1'b0;
        step(5);
        chk("s6_motor_before_rst", motor_on, 1);
        #2; rst = 1'b1;
        #1;
        chk("s6_rst_state_no_edge", state_o, S_IDLE);
        chk("s6_rst_outputs_no_edge", outs, 0);
        chk("s6_rst_rinse_cnt", rinse_cnt_o, 0);
        step(1);
        rst = 1'b0;

        // N_RINSE=0 instance: DRAIN_W goes straight to SPIN
        b_door = 1'b1; b_start = 1'b1;
        wait_st(1, S_FILL_SOAP, 4, "b_to_fill");
        b_start = 1'b0; b_filled = 1'b1; b_det = 1'b1;
        wait_st(1, S_WASH, 4, "b_to_wash");
        b_filled = 1'b0; b_det = 1'b0;
        wait_st(1, S_DRAIN_W, 6, "b_to_drain_w");
        b_drained = 1'b1;
        step(1);
        chk("b_drain_w_to_spin", b_state, S_SPIN);
        chk("b_rinse_cnt", b_rinse, 0);
        b_drained = 1'b0;
        step(3);
        chk("b_spin_hold", b_state, S_SPIN);
        step(1);
        chk("b_spin_to_done", b_state, S_DONE);
        chk("b_done_out", b_done, 1);

        step(1);
        chk("sb_all_consumed", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
